// File: rtl/cmp_flags_unit.sv
// Two-stage compare/condition unit: a - b produces ARM-style NZCV, evaluates a condition code
// and keeps a stored flags register. Define CMP_LT_OUTPUTS_EN to add lt_signed/lt_unsigned outputs.
module cmp_flags_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
    input  logic [3:0]       cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
`ifdef CMP_LT_OUTPUTS_EN
    output logic             lt_signed,
    output logic             lt_unsigned,
`endif
    output logic [3:0]       flags
);

    logic             s1_valid_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             set_flags_reg;
    logic [3:0]       cond_reg;

    logic             out_valid_reg;
    logic             taken_reg;
    logic [3:0]       flags_reg;

    logic             advance;
    logic             accept;
    logic [WIDTH:0]   diff;
    logic [3:0]       nzcv_next;
    logic [3:0]       eval_flags;
    logic             taken_next;

    // in_ready depends only on registered state and out_ready, never on in_valid.
    assign advance  = s1_valid_reg && (!out_valid_reg || out_ready);
    assign in_ready = !s1_valid_reg || advance;
    assign accept   = in_valid && in_ready;

    // Extra top bit of the difference is the borrow; carry is its inverse.
    assign diff = {1'b0, a_reg} - {1'b0, b_reg};

    always_comb begin
        nzcv_next    = 4'b0000;
        nzcv_next[3] = diff[WIDTH-1];
        nzcv_next[2] = (diff[WIDTH-1:0] == '0);
        nzcv_next[1] = !diff[WIDTH];
        nzcv_next[0] = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);
    end

    // A flag-setting request evaluates its own result; otherwise the stored flags apply.
    assign eval_flags = set_flags_reg ? nzcv_next : flags_reg;

    always_comb begin
        taken_next = 1'b1;
        case (cond_reg)
            4'h0: taken_next = eval_flags[2];
            4'h1: taken_next = !eval_flags[2];
            4'h2: taken_next = eval_flags[1];
            4'h3: taken_next = !eval_flags[1];
            4'h4: taken_next = eval_flags[3];
            4'h5: taken_next = !eval_flags[3];
            4'h6: taken_next = eval_flags[0];
            4'h7: taken_next = !eval_flags[0];
            4'h8: taken_next = eval_flags[1] && !eval_flags[2];
            4'h9: taken_next = !eval_flags[1] || eval_flags[2];
            4'hA: taken_next = (eval_flags[3] == eval_flags[0]);
            4'hB: taken_next = (eval_flags[3] != eval_flags[0]);
            4'hC: taken_next = !eval_flags[2] && (eval_flags[3] == eval_flags[0]);
            4'hD: taken_next = eval_flags[2] || (eval_flags[3] != eval_flags[0]);
            default: taken_next = 1'b1;
        endcase
    end

    // Operand capture carries no reset: s1_valid_reg qualifies it.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg         <= a;
            b_reg         <= b;
            set_flags_reg <= set_flags;
            cond_reg      <= cond;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            taken_reg     <= 1'b0;
            flags_reg     <= 4'b0000;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
            end else if (advance) begin
                s1_valid_reg <= 1'b0;
            end
            if (advance) begin
                out_valid_reg <= 1'b1;
                taken_reg     <= taken_next;
                if (set_flags_reg) begin
                    flags_reg <= nzcv_next;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef CMP_LT_OUTPUTS_EN
    logic lt_signed_reg;
    logic lt_unsigned_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            lt_signed_reg   <= 1'b0;
            lt_unsigned_reg <= 1'b0;
        end else if (advance) begin
            lt_signed_reg   <= (nzcv_next[3] != nzcv_next[0]);
            lt_unsigned_reg <= !nzcv_next[1];
        end
    end

    assign lt_signed   = lt_signed_reg;
    assign lt_unsigned = lt_unsigned_reg;
`endif

    assign out_valid = out_valid_reg;
    assign taken     = taken_reg;
    assign flags     = flags_reg;

endmodule

// File: tb/tb_cmp_flags_unit.sv
// Bench for cmp_flags_unit: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_cmp_flags_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         set_flags = 1'b0;
    logic [3:0]   cond = 4'h0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         taken;
    logic [3:0]   flags;
`ifdef CMP_LT_OUTPUTS_EN
    logic         lt_signed;
    logic         lt_unsigned;
`endif

    always #5 clk = ~clk;

    cmp_flags_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .set_flags  (set_flags),
        .cond       (cond),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .taken      (taken),
`ifdef CMP_LT_OUTPUTS_EN
        .lt_signed  (lt_signed),
        .lt_unsigned(lt_unsigned),
`endif
        .flags      (flags)
    );

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flags from arithmetic meaning: signed overflow is judged on the exact integer difference.
    function automatic logic [3:0] model_nzcv(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, t;
        logic [W-1:0] r;
        logic n, z, c, v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        t  = sx - sy;
        r  = x - y;
        n  = r[W-1];
        z  = (x == y);
        c  = (x >= y);
        v  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        return {n, z, c, v};
    endfunction

    // ARM style: odd codes are the negation of the even code below them, E/F always.
    function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] f);
        logic base;
        case (cc[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] && !f[2];
            3'd5: base = (f[3] == f[0]);
            3'd6: base = !f[2] && (f[3] == f[0]);
            default: return 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    typedef struct {
        logic       tk;
        logic [3:0] fl;
        logic       lts;
        logic       ltu;
        int         cyc;
    } ent_t;

    ent_t       q[$];
    logic [3:0] tail_flags = 4'b0000;
    logic [3:0] committed  = 4'b0000;
    int         edge_cnt   = 0;

    // Model: at most two requests in flight; the oldest reaches the output one edge after accept.
    always @(posedge clk) begin
        bit   ov_e, ir_e, pop, acc;
        ent_t e;
        logic [3:0] f;
        ov_e = (q.size() > 0) && (q[0].cyc < edge_cnt);
        ir_e = (q.size() < 2) || out_ready;
        pop  = ov_e && out_ready;
        acc  = in_valid && ir_e;
        edge_cnt++;
        if (reset) begin
            q.delete();
            tail_flags = 4'b0000;
            committed  = 4'b0000;
        end else begin
            if (pop) begin
                committed = q[0].fl;
                xfers++;
                $display("xfer %0d: taken=%0b flags=%b", xfers, q[0].tk, q[0].fl);
                void'(q.pop_front());
            end
            if (acc) begin
                f      = model_nzcv(a, b);
                e.fl   = set_flags ? f : tail_flags;
                e.tk   = model_cond(cond, e.fl);
                e.lts  = (f[3] != f[0]);
                e.ltu  = !f[1];
                e.cyc  = edge_cnt;
                tail_flags = e.fl;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        bit ov_e;
        if (chk_en) begin
            ov_e = (q.size() > 0) && (q[0].cyc < edge_cnt);
            chk("out_valid", out_valid, ov_e);
            chk("in_ready", in_ready, (q.size() < 2) || out_ready);
            chk("flags", flags, ov_e ? q[0].fl : committed);
            if (ov_e) begin
                chk("taken", taken, q[0].tk);
`ifdef CMP_LT_OUTPUTS_EN
                chk("lt_signed", lt_signed, q[0].lts);
                chk("lt_unsigned", lt_unsigned, q[0].ltu);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic sf, input logic [3:0] cc);
        in_valid  = iv;
        a         = aa;
        b         = bb;
        set_flags = sf;
        cond      = cc;
    endtask

    task automatic single(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [3:0] cc, input logic exp_tk, input logic [3:0] exp_fl);
        drive(1'b1, aa, bb, 1'b1, cc);
        tick();
        in_valid = 1'b0;
        chk({name, "_ov_early"}, out_valid, 1'b0);
        tick();
        chk({name, "_ov"}, out_valid, 1'b1);
        chk({name, "_taken"}, taken, exp_tk);
        chk({name, "_flags"}, flags, exp_fl);
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] pick [5];
        pick[0] = 32'h0000_0000;
        pick[1] = 32'h0000_0001;
        pick[2] = 32'h7FFF_FFFF;
        pick[3] = 32'h8000_0000;
        pick[4] = 32'hFFFF_FFFF;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return W'($urandom_range(0, 7));
            2: return pick[$urandom_range(0, 4)];
            default: return 32'h8000_0000 + W'($urandom_range(0, 3)) - 32'd2;
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_taken", taken, 1'b0);
        chk_en = 1'b1;
        reset  = 1'b0;

        chk("model_eq", model_nzcv(32'd5, 32'd5), 4'b0110);
        chk("model_ovf", model_nzcv(32'h7FFF_FFFF, 32'hFFFF_FFFF), 4'b1001);
        chk("model_lt", model_cond(4'hB, 4'b1000), 1'b1);
        chk("model_ls", model_cond(4'h9, 4'b0010), 1'b0);

        single("eq55", 32'd5, 32'd5, 4'h0, 1'b1, 4'b0110);
        tick();
        single("lt0_51", 32'd0, 32'd51, 4'hB, 1'b1, 4'b1000);
`ifdef CMP_LT_OUTPUTS_EN
        chk("lt0_51_lts", lt_signed, 1'b1);
        chk("lt0_51_ltu", lt_unsigned, 1'b1);
`endif
        tick();
        single("ge_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'hA, 1'b1, 4'b1001);
`ifdef CMP_LT_OUTPUTS_EN
        chk("ge_ovf_ltu", lt_unsigned, 1'b1);
`endif
        tick();

        // Back-to-back: the second request sees the first one's flags without a bubble.
        drive(1'b1, 32'd52315, 32'd0, 1'b1, 4'h8);
        tick();
        drive(1'b1, 32'd52315, 32'd0, 1'b0, 4'h8);
        tick();
        in_valid = 1'b0;
        chk("hi1_taken", taken, 1'b1);
        chk("hi1_flags", flags, 4'b0010);
        tick();
        chk("hi2_ov", out_valid, 1'b1);
        chk("hi2_taken", taken, 1'b1);
        chk("hi2_flags", flags, 4'b0010);
        tick();

        // Stall with three requests offered: two are taken, the third waits.
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd2, 1'b1, 4'hB);
        tick();
        chk("stall_ir1", in_ready, 1'b1);
        drive(1'b1, 32'd3, 32'd3, 1'b1, 4'h0);
        tick();
        chk("stall_ir2", in_ready, 1'b0);
        drive(1'b1, 32'd9, 32'd4, 1'b0, 4'h1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ov", out_valid, 1'b1);
            chk("stall_taken", taken, 1'b1);
            chk("stall_flags", flags, 4'b1000);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        chk("drain1_taken", taken, 1'b1);
        chk("drain1_flags", flags, 4'b0110);
        in_valid = 1'b0;
        tick();
        chk("drain2_ov", out_valid, 1'b1);
        chk("drain2_taken", taken, 1'b0);
        chk("drain2_flags", flags, 4'b0110);
        tick();
        chk("drain3_ov", out_valid, 1'b0);

        // Reset with both stages full.
        out_ready = 1'b0;
        drive(1'b1, 32'd7, 32'd3, 1'b1, 4'h0);
        tick();
        drive(1'b1, 32'd1, 32'd1, 1'b1, 4'h0);
        tick();
        chk("full_ov", out_valid, 1'b1);
        chk("full_ir", in_ready, 1'b0);
        reset = 1'b1;
        tick();
        chk("midrst_ov", out_valid, 1'b0);
        chk("midrst_flags", flags, 4'b0000);
        chk("midrst_ir", in_ready, 1'b1);
        chk("midrst_taken", taken, 1'b0);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("postrst_ov", out_valid, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = rand_operand();
            b         = ($urandom_range(0, 3) == 0) ? a : rand_operand();
            set_flags = $urandom_range(0, 1);
            cond      = 4'($urandom_range(0, 15));
            reset     = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
